uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- UART receive control stage, directly upstream and downstream of the oversampling majority-vote sampler (DATA_SAMPLING).
- Detects the start bit and runs the per-bit edge counter and bit counter.
- Drives data_samp_en and edge_counter to the sampler.
- Consumes sampled_bit; deserializes LSB-first; checks the parity and stop bits; presents a parallel byte with a one-cycle valid pulse.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_W, 5, width of prescale and edge_counter.

Ports:
- CLK  in  1  oversampling clock.
- RST  in  1  asynchronous active-low reset.
- RX_IN  in  1  serial line, idle high; already synchronized upstream.
- prescale  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32; quasi-static, changed only while idle.
- par_en  in  1  parity bit present.
- par_typ  in  1  0 = even, 1 = odd.
- sampled_bit  in  1  registered majority vote from the sampler.
- data_samp_en  out  1  sampler enable.
- edge_counter  out  PRESCALE_W  oversample index within the current bit.
- p_data  out  DATA_WIDTH  received byte.
- data_valid  out  1  one-cycle pulse; p_data is valid in that cycle.
- parity_error  out  1  parity mismatch on the last frame.
- stop_error  out  1  stop bit sampled low on the last frame.

Behaviour:
- Reset values: every output 0, p_data = 0; FSM in IDLE; internal counters and shift register 0.
- Tap definition:
  - TAP = (prescale>>1) + 2 (sampler result latency); value 6/10/18 for prescale 8/16/32.
  - sampled_bit is consumed only in the cycle where edge_counter == TAP.
- Edge counter:
  - Counts 0..prescale-1, then wraps to 0 and increments bit_cnt.
  - Held at 0, with bit_cnt 0, in IDLE.
- data_samp_en = 1 in every state except IDLE.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - RX_IN == 0 -> START; the edge counter begins at 0 on the next cycle.
  - Errors are held until the next start.
- START:
  - At TAP, sampled_bit == 1 -> glitch: back to IDLE immediately, no flags raised.
  - At edge_counter == prescale-1 -> DATA; parity_error and stop_error cleared.
- DATA:
  - At TAP, shift sampled_bit into the shift register, LSB first.
  - After bit DATA_WIDTH-1 ends (bit_cnt wrap at the last edge) -> PARITY if par_en, else STOP.
- PARITY:
  - At TAP, compute even parity of the shift register XOR par_typ; mismatch with sampled_bit sets parity_error.
  - At end of bit -> STOP.
- STOP:
  - At TAP, stop_error = ~sampled_bit.
  - At TAP + 1 -> IDLE. This early exit tolerates back-to-back frames with clock drift.
  - Same cycle: if neither error is set, p_data <= shift register and data_valid = 1 for exactly one cycle. Otherwise p_data holds its old value and no pulse is issued.
- Error flags are sticky from detection until the next START entry.
- RX_IN is ignored outside IDLE; the sampler alone observes the line.
- Reset asserted mid-frame: immediate return to reset values; no data_valid.
- A prescale change mid-frame is illegal; behaviour is undefined but must not lock up, and the FSM recovers at the next IDLE.

Optional Feature:
- Macro UART_RX_BREAK_DET_EN adds output break_det (1 bit, reset 0).
- With the macro: a frame with all data bits 0 and stop bit 0 pulses break_det for one cycle at STOP exit, suppresses stop_error, and produces no data_valid.
- FSM then waits in IDLE for RX_IN == 1 for one full bit time before accepting a new start.
- Without the macro: no break_det port; such a frame simply sets stop_error.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, 3-bit encoding);
  - DATA_WIDTH and PRESCALE_W defaults;
  - legal prescale constants;
  - the TAP_OFFSET = 2 constant.
- Sub-module uart_rx_edge_bit_cnt (enable, prescale -> edge_counter, bit_cnt, bit_end strobe).
- FSM, shift register and checkers stay in the top module.

Test Plan:
- prescale 8, no parity, frame 0xA5 -> data_valid pulse with p_data = 0xA5; stop_error = 0; exactly 1 pulse.
- prescale 16, par_en = 1, par_typ = 0, byte 0x03 with parity bit 1 -> parity_error = 1, no data_valid.
- Start pulse low for 3 cycles at prescale 16 -> returns to IDLE; data_samp_en drops after TAP; no flags.
- prescale 32, byte 0x5A with stop bit 0 -> stop_error = 1, p_data keeps its previous value.
- Two back-to-back frames 0x12 and 0x34 at prescale 8 -> two pulses with the correct bytes; the second start is caught after the early STOP exit.
- Reset asserted mid-DATA at prescale 16 -> all outputs 0 next cycle; the following frame 0xFF is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive control slice.
// Latency: n/a (package only).
// Backpressure: n/a; the receiver has no ready input, it follows the serial line.
// Contents: FSM state enum, default widths, legal oversampling ratios and the
// sampler result latency that positions the sampling tap within a bit.
package uart_rx_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESCALE_W_DEF = 5;

    // Legal oversampling ratios. A ratio of 2**PRESCALE_W does not fit the
    // prescale port, so it is encoded as 0 (32 -> 5'd0 with the default width).
    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    // Cycles from the mid-bit sample window to a registered majority vote.
    localparam int TAP_OFFSET = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Per-bit oversample counter plus bit counter for the UART receiver.
// Latency: counters update one cycle after i_en; o_bit_end is combinational.
// Backpressure: none; counts every cycle while enabled, clears when disabled.
// Ports: i_clk, i_rst_n (async active-low), i_en (run, else clear to 0),
//        i_prescale (oversampling ratio, 0 encodes 2**PRESCALE_W),
//        o_edge (0..prescale-1), o_bit_cnt (completed bits), o_bit_end (last edge).
module uart_rx_edge_bit_cnt #(
    parameter int PRESCALE_W = 5,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic [PRESCALE_W-1:0] o_edge,
    output logic [BIT_CNT_W-1:0]  o_bit_cnt,
    output logic                  o_bit_end
);

    localparam logic [PRESCALE_W-1:0] ONE_P = {{(PRESCALE_W-1){1'b0}}, 1'b1};
    localparam logic [BIT_CNT_W-1:0]  ONE_B = {{(BIT_CNT_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] w_last;

    // Wraps naturally: prescale 0 (meaning 2**PRESCALE_W) gives an all-ones last edge.
    assign w_last = i_prescale - ONE_P;

    // '>=' rather than '==' so a prescale lowered mid-frame still wraps promptly.
    assign o_bit_end = i_en && (o_edge >= w_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_edge    <= '0;
            o_bit_cnt <= '0;
        end else if (!i_en) begin
            o_edge    <= '0;
            o_bit_cnt <= '0;
        end else if (o_bit_end) begin
            o_edge    <= '0;
            o_bit_cnt <= o_bit_cnt + ONE_B;
        end else begin
            o_edge    <= o_edge + ONE_P;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: start detect, bit timing, LSB-first deserialize, parity/stop check.
// Latency: data_valid/p_data one cycle after the STOP tap+1 edge (mid stop bit + 3 cycles).
// Backpressure: none; data_valid is a one-cycle pulse that must be taken when issued.
// Ports: CLK, RST (async active-low), RX_IN (idle high), prescale (8/16/32, 32 encoded as 0),
//        par_en, par_typ (0 even / 1 odd), sampled_bit (from sampler) ->
//        data_samp_en, edge_counter (to sampler), p_data, data_valid, parity_error, stop_error.
// Optional: define UART_RX_BREAK_DET_EN to add the break_det output and break handling.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  sampled_bit,
    output logic                  data_samp_en,
    output logic [PRESCALE_W-1:0] edge_counter,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  parity_error,
`ifdef UART_RX_BREAK_DET_EN
    output logic                  break_det,
`endif
    output logic                  stop_error
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 3);
    localparam logic [PRESCALE_W:0]  TAP_OFF   = (PRESCALE_W+1)'(TAP_OFFSET);
    localparam logic [PRESCALE_W:0]  ONE_W     = {{PRESCALE_W{1'b0}}, 1'b1};
    // bit_cnt is 0 during the start bit, so data bit i runs with bit_cnt = i+1.
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_WIDTH);

    state_t r_state, w_state_nxt;

    logic [PRESCALE_W:0]   w_ps_full, w_tap, w_tap_p1, w_edge_ext;
    logic                  w_at_tap, w_at_exit, w_bit_end, w_run;
    logic                  w_stop_exit, w_idle_ok, w_brk_frame, w_brk_pend;
    logic [BIT_CNT_W-1:0]  w_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;

    // Restore the missing top bit: prescale 0 stands for 2**PRESCALE_W.
    assign w_ps_full  = {(prescale == '0), prescale};
    assign w_tap      = (w_ps_full >> 1) + TAP_OFF;
    assign w_tap_p1   = w_tap + ONE_W;
    assign w_edge_ext = {1'b0, edge_counter};
    assign w_at_tap   = (w_edge_ext == w_tap);
    assign w_at_exit  = (w_edge_ext == w_tap_p1);

    assign data_samp_en = (r_state != ST_IDLE);

    // Counter runs only while staying out of IDLE, so it reads 0 in every IDLE cycle.
    assign w_run = (r_state != ST_IDLE) && (w_state_nxt != ST_IDLE);

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_edge_bit_cnt (
        .i_clk      (CLK),
        .i_rst_n    (RST),
        .i_en       (w_run),
        .i_prescale (prescale),
        .o_edge     (edge_counter),
        .o_bit_cnt  (w_bit_cnt),
        .o_bit_end  (w_bit_end)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (!RX_IN && w_idle_ok) w_state_nxt = ST_START;
            ST_START:  if (w_at_tap && sampled_bit) w_state_nxt = ST_IDLE;
                       else if (w_bit_end)          w_state_nxt = ST_DATA;
            ST_DATA:   if (w_bit_end && (w_bit_cnt == DATA_LAST))
                           w_state_nxt = par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_bit_end) w_state_nxt = ST_STOP;
            // Leave mid stop bit so a back-to-back start edge is not missed under drift;
            // the bit_end escape keeps an illegal prescale change from trapping us here.
            ST_STOP:   if (w_at_exit || w_bit_end) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_stop_exit = (r_state == ST_STOP) && (w_state_nxt == ST_IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            p_data       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            data_valid <= 1'b0;
            if ((r_state == ST_START) && (w_state_nxt == ST_DATA)) begin
                parity_error <= 1'b0;
                stop_error   <= 1'b0;
            end
            if ((r_state == ST_DATA) && w_at_tap)
                r_shift <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
            if ((r_state == ST_PARITY) && w_at_tap && (((^r_shift) ^ par_typ) != sampled_bit))
                parity_error <= 1'b1;
            if ((r_state == ST_STOP) && w_at_tap)
                stop_error <= ~sampled_bit & ~w_brk_frame;
            if (w_stop_exit && !parity_error && !stop_error && !w_brk_pend) begin
                p_data     <= r_shift;
                data_valid <= 1'b1;
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    localparam logic [PRESCALE_W-1:0] ONE_P = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic                  r_brk_pend, r_brk_wait;
    logic [PRESCALE_W-1:0] r_idle_cnt, w_ps_last;

    assign w_ps_last   = prescale - ONE_P;
    assign w_brk_frame = (r_shift == '0) && !sampled_bit;
    assign w_brk_pend  = r_brk_pend;
    // After a break the line must sit high for a whole bit before a start counts.
    assign w_idle_ok   = ~r_brk_wait;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_brk_pend <= 1'b0;
            r_brk_wait <= 1'b0;
            r_idle_cnt <= '0;
            break_det  <= 1'b0;
        end else begin
            break_det <= 1'b0;
            if ((r_state == ST_START) && (w_state_nxt == ST_DATA))
                r_brk_pend <= 1'b0;
            if ((r_state == ST_STOP) && w_at_tap)
                r_brk_pend <= w_brk_frame;
            if (w_stop_exit && r_brk_pend) begin
                break_det  <= 1'b1;
                r_brk_pend <= 1'b0;
                r_brk_wait <= 1'b1;
                r_idle_cnt <= '0;
            end else if (r_brk_wait && (r_state == ST_IDLE)) begin
                if (!RX_IN) begin
                    r_idle_cnt <= '0;
                end else if (r_idle_cnt >= w_ps_last) begin
                    r_brk_wait <= 1'b0;
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + ONE_P;
                end
            end
        end
    end
`else
    assign w_brk_frame = 1'b0;
    assign w_brk_pend  = 1'b0;
    assign w_idle_ok   = 1'b1;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frames plus random frames,
// with a behavioural mid-bit majority sampler and a queue-based byte scoreboard.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int DW = 8;
    localparam int PW = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic [PW-1:0] prescale;
    logic          par_en;
    logic          par_typ;
    logic          sampled_bit;
    logic          data_samp_en;
    logic [PW-1:0] edge_counter;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          parity_error;
    logic          stop_error;
`ifdef UART_RX_BREAK_DET_EN
    logic          break_det;
`endif

    int ps_cur  = 8;
    int n_cmp   = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_brk   = 0;
    int m_brk   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_pdata = 8'h00;
    bit         m_perr  = 1'b0;
    bit         m_serr  = 1'b0;
    logic       s0, s1;

    always #5 CLK = ~CLK;

    uart_rx_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .prescale     (prescale),
        .par_en       (par_en),
        .par_typ      (par_typ),
        .sampled_bit  (sampled_bit),
        .data_samp_en (data_samp_en),
        .edge_counter (edge_counter),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .parity_error (parity_error),
`ifdef UART_RX_BREAK_DET_EN
        .break_det    (break_det),
`endif
        .stop_error   (stop_error)
    );

    // Upstream sampler: majority of three samples around mid-bit, registered.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0 <= 1'b0; s1 <= 1'b0; sampled_bit <= 1'b0;
        end else if (data_samp_en) begin
            if (int'(edge_counter) == ps_cur/2 - 1) s0 <= RX_IN;
            if (int'(edge_counter) == ps_cur/2)     s1 <= RX_IN;
            if (int'(edge_counter) == ps_cur/2 + 1)
                sampled_bit <= (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every data_valid pulse must match the oldest expected byte.
    always @(negedge CLK) begin
        if (RST && data_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got pulse with p_data 0x%0h, expected no pulse", p_data);
            end else begin
                check("p_data", 32'(p_data), 32'(exp_q.pop_front()));
            end
        end
`ifdef UART_RX_BREAK_DET_EN
        if (RST && break_det) n_brk++;
`endif
    end

    task automatic set_ps(input int p);
        ps_cur   = p;
        prescale = p[PW-1:0];
    endtask

    task automatic drive_bit(input logic b);
        RX_IN = b;
        repeat (ps_cur) @(negedge CLK);
    endtask

    // Reference model: frame-level outcome from the protocol rules, then drive the line.
    task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt,
                              input logic pbit, input logic stop, input int gap);
        bit perr, serr, brk;
        par_en  = pe;
        par_typ = pt;
        // Even parity: ones in data+parity even; odd parity: odd.
        perr = pe && ((($countones(d) + int'(pbit)) % 2) != int'(pt));
        brk  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk  = (d == 8'h00) && (stop == 1'b0);
`endif
        serr = (stop == 1'b0) && !brk;
        m_perr = perr;
        m_serr = serr;
        if (brk) m_brk++;
        if (!perr && !serr && !brk) begin
            exp_q.push_back(d);
            m_pdata = d;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pe) drive_bit(pbit);
        drive_bit(stop);
        RX_IN = 1'b1;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_parity_error"}, 32'(parity_error), 32'(m_perr));
        check({tag, "_stop_error"},   32'(stop_error),   32'(m_serr));
        check({tag, "_p_data_held"},  32'(p_data),       32'(m_pdata));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_samp_en"}, 32'(data_samp_en), 32'd0);
        check({tag, "_edge_counter"}, 32'(edge_counter), 32'd0);
        check({tag, "_p_data"},       32'(p_data),       32'd0);
        check({tag, "_data_valid"},   32'(data_valid),   32'd0);
        check({tag, "_parity_error"}, 32'(parity_error), 32'd0);
        check({tag, "_stop_error"},   32'(stop_error),   32'd0);
    endtask

    initial begin
        int ps_tab[3];
        logic [7:0] d;
        int p;
        ps_tab = '{PRESCALE_8, PRESCALE_16, PRESCALE_32};

        RST = 1'b0; RX_IN = 1'b1; par_en = 1'b0; par_typ = 1'b0;
        set_ps(8);
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b1;
        repeat (4) @(negedge CLK);

        // Prescale 8, no parity, 0xA5.
        set_ps(8);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 16);
        check_flags("t1");
        check("t1_pulses", 32'(n_valid), 32'd1);

        // Prescale 16, even parity, 0x03 with parity bit 1 -> parity error.
        set_ps(16);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 32);
        check("t2_parity_error_set", 32'(parity_error), 32'd1);
        check_flags("t2");
        check("t2_pulses", 32'(n_valid), 32'd1);

        // Start glitch, 3 cycles low at prescale 16.
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        check("t3_samp_en_during", 32'(data_samp_en), 32'd1);
        repeat (10) @(negedge CLK);
        check("t3_samp_en_after", 32'(data_samp_en), 32'd0);
        check("t3_edge_after", 32'(edge_counter), 32'd0);
        check_flags("t3");
        repeat (16) @(negedge CLK);

        // Prescale 32, 0x5A with stop bit 0 -> stop error, p_data holds 0xA5.
        set_ps(32);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 64);
        check("t4_stop_error_set", 32'(stop_error), 32'd1);
        check("t4_p_data_held", 32'(p_data), 32'hA5);
        check_flags("t4");

        // Back-to-back frames at prescale 8.
        set_ps(8);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 16);
        check_flags("t5");
        check("t5_pulses", 32'(n_valid), 32'd3);

        // Reset mid-DATA at prescale 16, then 0xFF.
        set_ps(16);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        RX_IN = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        m_pdata = 8'h00; m_perr = 1'b0; m_serr = 1'b0;
        @(negedge CLK);
        check_all_zero("t6_reset");
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        RX_IN = 1'b1;
        repeat (32) @(negedge CLK);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 32);
        check_flags("t6");
        check("t6_pulses", 32'(n_valid), 32'd4);

        // Random frames: ratio, parity mode, parity bit, stop bit, data.
        for (int n = 0; n < 24; n++) begin
            p = ps_tab[$urandom_range(0, 2)];
            set_ps(p);
            d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            send_frame(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0),
                       2*p + int'($urandom_range(0, 4)));
            check_flags("rand");
        end

        repeat (10) @(negedge CLK);
        check("pending_expected", 32'(exp_q.size()), 32'd0);
`ifdef UART_RX_BREAK_DET_EN
        check("break_pulses", 32'(n_brk), 32'(m_brk));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
